// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access stage between EX/MEM and MEM/WB. Each load/store is run
//   against a variable-latency data memory over a req/ack handshake. The
//   front of the pipeline is stalled while an access is outstanding, and a
//   bubble (RegWrite_o=0) is sent to MEM/WB on every stalled cycle.
//
// Ports
//   clk_i, rst_i           clock (rising edge), async active-high reset
//   MemRead_i/MemWrite_i   load / store in stage
//   RegWrite_i, RD_i       writeback control from EX/MEM
//   Result_i               ALU result, also the memory address
//   WriteData_i            store data
//   RegWrite_o, Data_o,
//   Result_o, RD_o         to MEM/WB
//   Stall_o                to hazard unit
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o registered memory request
//   mem_ack_i, mem_rdata_i memory completion pulse and read data
//   err_o                  sticky error (misaligned, read+write, timeout)
module mem_access_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic [DATA_W-1:0] Result_i,
    input  logic [DATA_W-1:0] WriteData_i,
    input  logic [4:0]        RD_i,
    output logic              RegWrite_o,
    output logic [DATA_W-1:0] Data_o,
    output logic [DATA_W-1:0] Result_o,
    output logic [4:0]        RD_o,
    output logic              Stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_cnt;
    logic [DATA_W-1:0] r_data;

    logic w_access;
    logic w_misaligned;
    logic w_timeout;

    assign w_access     = MemRead_i | MemWrite_i;
    assign w_misaligned = (Result_i[1:0] != 2'b00);
    // Last permitted WAIT cycle: no ack here means abort.
    assign w_timeout    = (r_cnt == 16'(TIMEOUT - 1));

    assign Result_o = Result_i;
    assign RD_o     = RD_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        Stall_o    = 1'b0;
        RegWrite_o = 1'b0;
        Data_o     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    Stall_o = 1'b1;
                    w_next  = w_misaligned ? S_RESP : S_WAIT;
                end else begin
                    RegWrite_o = RegWrite_i;
                end
            end
            S_WAIT: begin
                Stall_o = 1'b1;
                if (mem_ack_i || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                RegWrite_o = RegWrite_i;
                Data_o     = r_data;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            err_o       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_misaligned) begin
                            err_o  <= 1'b1;
                            r_data <= '0;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= MemWrite_i;
                            mem_addr_o  <= Result_i;
                            mem_wdata_o <= WriteData_i;
                            r_cnt       <= '0;
                            // Simultaneous read+write is executed as a write.
                            if (MemRead_i && MemWrite_i) begin
                                err_o <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        r_data    <= mem_we_o ? '0 : mem_rdata_i;
                    end else if (w_timeout) begin
                        mem_req_o <= 1'b0;
                        r_data    <= '0;
                        err_o     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It runs each load/store against a variable-latency data memory using a req/ack handshake, and stalls the front of the pipeline while an access is outstanding. It presents RegWrite/Data/Result/RD to MEM/WB, which captures them on every edge, and inserts a bubble (RegWrite_o=0) on every cycle the stage is stalled.

Parameters:
DATA_W, 32, width of data, ALU result and memory address
TIMEOUT, 255, max cycles in WAIT without mem_ack_i before abort (1..2^16-1)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
MemRead_i  input  1  load in stage (from EX/MEM)
MemWrite_i  input  1  store in stage (from EX/MEM)
RegWrite_i  input  1  register write enable (from EX/MEM)
Result_i  input  DATA_W  ALU result; the memory address for loads/stores
WriteData_i  input  DATA_W  store data
RD_i  input  5  destination register
RegWrite_o  output  1  to MEM/WB
Data_o  output  DATA_W  load data to MEM/WB
Result_o  output  DATA_W  to MEM/WB
RD_o  output  5  to MEM/WB
Stall_o  output  1  to hazard unit; holds PC, IF/ID, ID/EX, EX/MEM
mem_req_o  output  1  memory request, registered
mem_we_o  output  1  1=write, registered
mem_addr_o  output  DATA_W  registered address
mem_wdata_o  output  DATA_W  registered write data
mem_ack_i  input  1  access complete, one-cycle pulse
mem_rdata_i  input  DATA_W  read data, valid with mem_ack_i
err_o  output  1  sticky error flag

Behaviour:
- Reset is asynchronous, active-high. It forces state=IDLE; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, data_r, wait counter and err_o all go to 0. Combinational outputs then follow the IDLE rules below.
- Define access = MemRead_i | MemWrite_i.
- Result_o and RD_o always equal Result_i and RD_i (combinational).
- States: IDLE, WAIT, RESP.
- IDLE, access=0:
  - RegWrite_o=RegWrite_i, Data_o=0, Stall_o=0.
  - Stays in IDLE. Zero added latency; an instruction passes through in one cycle.
- IDLE, access=1:
  - Stall_o=1, RegWrite_o=0, Data_o=0.
  - If Result_i[1:0]!=0 (misaligned): no request is issued, err_o<=1, next state RESP, data_r<=0.
  - Otherwise: on the edge, mem_req_o<=1, mem_we_o<=MemWrite_i, mem_addr_o<=Result_i, mem_wdata_o<=WriteData_i, counter<=0, next state WAIT.
  - If MemRead_i and MemWrite_i are both 1: performed as a write, and err_o<=1.
- WAIT:
  - Stall_o=1, RegWrite_o=0, Data_o=0.
  - mem_req_o and the address/data/we registers hold stable until ack.
  - mem_ack_i=1 at edge: data_r<=mem_rdata_i (writes capture 0), mem_req_o<=0, next state RESP.
  - No ack: counter increments. When counter==TIMEOUT-1 with no ack: mem_req_o<=0, data_r<=0, err_o<=1, next state RESP.
- RESP:
  - Stall_o=0, RegWrite_o=RegWrite_i, Data_o=data_r.
  - Next state IDLE unconditionally. On this edge EX/MEM advances and MEM/WB captures the result.
- Minimum access occupancy is 3 cycles (IDLE, WAIT with ack in its first cycle, RESP). Each extra cycle without ack adds one WAIT cycle.
- mem_ack_i asserted in IDLE or RESP is ignored.
- err_o stays high until reset. err_o does not block later accesses.
- Reset during WAIT drops mem_req_o immediately (asynchronously). The outstanding access is abandoned, and any late ack is ignored.
- Inputs are assumed stable while Stall_o=1 (EX/MEM is held).

Test Plan:
1. ALU op (MemRead=MemWrite=0, RegWrite=1, Result=0x1234, RD=5) -> same cycle RegWrite_o=1, Result_o=0x1234, RD_o=5, Stall_o=0, mem_req_o never rises.
2. Load at 0x40, ack one cycle after req, rdata=0xDEADBEEF -> Stall_o=1 for 2 cycles, RegWrite_o=0 while stalled. In RESP: Data_o=0xDEADBEEF, RegWrite_o=1, Stall_o=0. mem_req_o high for exactly 1 cycle with mem_addr_o=0x40, mem_we_o=0.
3. Store 0x55AA55AA to 0x80, ack delayed 5 cycles -> mem_we_o=1 and mem_wdata_o=0x55AA55AA held stable for 5 cycles. Stall_o high for 6 cycles, then RESP with RegWrite_o=RegWrite_i. err_o stays 0.
4. Load at 0x42 -> no mem_req_o, err_o=1, RESP on the next cycle with Data_o=0.
5. TIMEOUT=4, load, no ack -> mem_req_o drops after 4 cycles, err_o=1, RESP with Data_o=0. A later ack pulse is ignored (state IDLE, no change).
6. rst_i asserted mid-WAIT -> mem_req_o and err_o go to 0 immediately without a clock edge, Stall_o=0. A back-to-back load after release completes normally.
